// File: rtl/dmi_req_arbiter.sv
// Round-robin arbiter sharing one DMI request/response channel between several
// debug requesters; an in-order ID FIFO routes each response back to its issuer.

package dm;
    typedef enum logic [1:0] {
        DTM_NOP   = 2'h0,
        DTM_READ  = 2'h1,
        DTM_WRITE = 2'h2
    } dtm_op_e;

    typedef struct packed {
        logic [6:0]  addr;
        dtm_op_e     op;
        logic [31:0] data;
    } dmi_req_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } dmi_resp_t;
endpackage

module dmi_req_arbiter #(
    parameter int unsigned NumReq         = 2,
    parameter int unsigned MaxOutstanding = 4
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             dmi_clear_i,
    input  dm::dmi_req_t [NumReq-1:0]        req_i,
    input  logic [NumReq-1:0]                req_valid_i,
    output logic [NumReq-1:0]                req_ready_o,
    output dm::dmi_resp_t                    resp_o,
    output logic [NumReq-1:0]                resp_valid_o,
    input  logic [NumReq-1:0]                resp_ready_i,
    output dm::dmi_req_t                     dmi_req_o,
    output logic                             dmi_req_valid_o,
    input  logic                             dmi_req_ready_i,
    input  dm::dmi_resp_t                    dmi_resp_i,
    input  logic                             dmi_resp_valid_i,
    output logic                             dmi_resp_ready_o,
    output logic [$clog2(MaxOutstanding):0]  outstanding_o,
    output logic                             resp_drop_o
);

    localparam int unsigned IdxW = $clog2(NumReq);
    localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int unsigned CntW = $clog2(MaxOutstanding) + 1;

    function automatic logic [IdxW-1:0] req_inc(input logic [IdxW-1:0] idx);
        logic [IdxW-1:0] res;
        if (idx == IdxW'(NumReq - 1)) begin
            res = {IdxW{1'b0}};
        end else begin
            res = idx + IdxW'(1);
        end
        return res;
    endfunction

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
        logic [PtrW-1:0] res;
        if (ptr == PtrW'(MaxOutstanding - 1)) begin
            res = {PtrW{1'b0}};
        end else begin
            res = ptr + PtrW'(1);
        end
        return res;
    endfunction

    logic [IdxW-1:0] rr_q, rr_d;
    logic            lock_q, lock_d;
    logic [IdxW-1:0] gnt_q, gnt_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            drop_q, drop_d;
    logic [IdxW-1:0] fifo_q [MaxOutstanding];

    logic [IdxW:0]   sum_s;
    logic [IdxW-1:0] scan_gnt_s;
    logic [IdxW-1:0] grant_s;
    logic [IdxW-1:0] head_s;
    logic            full_s;
    logic            empty_s;
    logic            accept_s;
    logic            pop_s;

    // Round-robin scan: walk downward so the last hit is the nearest requester at or above rr
    always_comb begin
        scan_gnt_s = rr_q;
        sum_s      = {(IdxW+1){1'b0}};
        for (int k = NumReq - 1; k >= 0; k--) begin
            sum_s = {1'b0, rr_q} + (IdxW+1)'(k);
            if (sum_s >= (IdxW+1)'(NumReq)) begin
                sum_s = sum_s - (IdxW+1)'(NumReq);
            end else begin
                sum_s = sum_s;
            end
            if (req_valid_i[sum_s[IdxW-1:0]]) begin
                scan_gnt_s = sum_s[IdxW-1:0];
            end else begin
                scan_gnt_s = scan_gnt_s;
            end
        end
    end

    // Grant selection and the combinational request path
    always_comb begin
        if (lock_q) begin
            grant_s = gnt_q;
        end else begin
            grant_s = scan_gnt_s;
        end
        full_s    = (cnt_q == CntW'(MaxOutstanding));
        dmi_req_o = req_i[grant_s];
        // rst_ni gating keeps the handshake quiet while reset is held
        dmi_req_valid_o = req_valid_i[grant_s] & ~full_s & ~dmi_clear_i & rst_ni;
        for (int i = 0; i < NumReq; i++) begin
            req_ready_o[i] = (grant_s == IdxW'(i)) & dmi_req_ready_i & ~full_s
                             & ~dmi_clear_i & rst_ni;
        end
        accept_s = dmi_req_valid_o & dmi_req_ready_i;
    end

    // Response routing to the requester at the FIFO head, or discard when nothing is pending
    always_comb begin
        empty_s      = (cnt_q == {CntW{1'b0}});
        head_s       = fifo_q[rd_ptr_q];
        resp_o       = dmi_resp_i;
        resp_valid_o = {NumReq{1'b0}};
        if (!empty_s) begin
            resp_valid_o[head_s] = dmi_resp_valid_i;
            dmi_resp_ready_o     = resp_ready_i[head_s];
            pop_s                = dmi_resp_valid_i & resp_ready_i[head_s];
            drop_d               = 1'b0;
        end else begin
            resp_valid_o     = {NumReq{1'b0}};
            dmi_resp_ready_o = 1'b1;
            pop_s            = 1'b0;
            drop_d           = dmi_resp_valid_i;
        end
    end

    // Next-state for arbitration, lock and FIFO bookkeeping; a clear wins over everything
    always_comb begin
        rr_d     = rr_q;
        lock_d   = lock_q;
        gnt_d    = gnt_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (dmi_clear_i) begin
            rr_d     = {IdxW{1'b0}};
            lock_d   = 1'b0;
            gnt_d    = {IdxW{1'b0}};
            wr_ptr_d = {PtrW{1'b0}};
            rd_ptr_d = {PtrW{1'b0}};
            cnt_d    = {CntW{1'b0}};
        end else begin
            if (accept_s) begin
                rr_d     = req_inc(grant_s);
                lock_d   = 1'b0;
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end else if (dmi_req_valid_o) begin
                lock_d = 1'b1;
                gnt_d  = grant_s;
            end else begin
                lock_d = lock_q;
            end
            if (pop_s) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({accept_s, pop_s})
                2'b10:   cnt_d = cnt_q + CntW'(1);
                2'b01:   cnt_d = cnt_q - CntW'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // Control state registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q     <= {IdxW{1'b0}};
            lock_q   <= 1'b0;
            gnt_q    <= {IdxW{1'b0}};
            wr_ptr_q <= {PtrW{1'b0}};
            rd_ptr_q <= {PtrW{1'b0}};
            cnt_q    <= {CntW{1'b0}};
            drop_q   <= 1'b0;
        end else begin
            rr_q     <= rr_d;
            lock_q   <= lock_d;
            gnt_q    <= gnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            drop_q   <= drop_d;
        end
    end

    // ID FIFO storage; accept_s is already suppressed during a clear
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < MaxOutstanding; i++) begin
                fifo_q[i] <= {IdxW{1'b0}};
            end
        end else if (accept_s) begin
            fifo_q[wr_ptr_q] <= grant_s;
        end else begin
            fifo_q[wr_ptr_q] <= fifo_q[wr_ptr_q];
        end
    end

    assign outstanding_o = cnt_q;
    assign resp_drop_o   = drop_q;

endmodule

// File: tb/tb_dmi_req_arbiter.sv
// Self-checking bench for dmi_req_arbiter: vector table, directed corner cases and
// random traffic against a queue-based reference model.

module tb_dmi_req_arbiter;
    localparam int NR = 2;
    localparam int MO = 4;
    localparam int IW = $clog2(NR);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                    rst_n;
    logic                    clr;
    dm::dmi_req_t [NR-1:0]   req;
    logic [NR-1:0]           req_valid, req_ready, resp_valid, resp_ready;
    dm::dmi_resp_t           resp, dmi_resp;
    dm::dmi_req_t            dmi_req;
    logic                    dmi_req_valid, dmi_req_ready;
    logic                    dmi_resp_valid, dmi_resp_ready;
    logic [$clog2(MO):0]     outstanding;
    logic                    drop;

    dmi_req_arbiter #(.NumReq(NR), .MaxOutstanding(MO)) dut (
        .clk_i(clk), .rst_ni(rst_n), .dmi_clear_i(clr),
        .req_i(req), .req_valid_i(req_valid), .req_ready_o(req_ready),
        .resp_o(resp), .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
        .dmi_req_o(dmi_req), .dmi_req_valid_o(dmi_req_valid), .dmi_req_ready_i(dmi_req_ready),
        .dmi_resp_i(dmi_resp), .dmi_resp_valid_i(dmi_resp_valid), .dmi_resp_ready_o(dmi_resp_ready),
        .outstanding_o(outstanding), .resp_drop_o(drop)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // reference model: pending requester IDs in issue order
    int idq[$];
    int m_rr;
    bit m_lock;
    int m_lockid;
    bit m_drop;

    // values sampled in the most recent cycle
    logic          s_dval;
    logic [6:0]    s_addr;
    logic [NR-1:0] s_rready, s_rvalid;
    logic          s_drr;
    int            s_out;
    logic          s_drop;

    typedef struct {
        logic [NR-1:0] rv;
        logic          rdy;
        logic          dv;
        logic [NR-1:0] rrd;
        logic          e_dval;
        logic [6:0]    e_addr;
        logic [NR-1:0] e_rready;
        logic [NR-1:0] e_rvalid;
        logic          e_drr;
        int            e_out;
        logic          e_drop;
    } vec_t;
    vec_t tbl[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fixed_payload();
        for (int i = 0; i < NR; i++) begin
            req[IW'(i)].addr = 7'(7'h10 + i);
            req[IW'(i)].op   = dm::DTM_READ;
            req[IW'(i)].data = 32'(i);
        end
        dmi_resp.data = 32'hDEADBEEF;
        dmi_resp.resp = 2'b00;
    endtask

    task automatic model_reset();
        idq.delete();
        m_rr     = 0;
        m_lock   = 1'b0;
        m_lockid = 0;
        m_drop   = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; clr = 1'b0; req_valid = '0; dmi_req_ready = 1'b0;
        dmi_resp_valid = 1'b0; resp_ready = '0;
        fixed_payload();
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    // one clock: drive, compare against the model, clock, advance the model
    task automatic cycle(input logic [NR-1:0] rv, input logic rdy, input logic c,
                         input logic dv, input logic [NR-1:0] rrd);
        int g;
        bit found, full, expv, pop, dnext, exp_drr;
        logic [NR-1:0] exp_rr, exp_rv;
        req_valid = rv; dmi_req_ready = rdy; clr = c; dmi_resp_valid = dv; resp_ready = rrd;
        #2;
        if (m_lock) begin
            g = m_lockid;
        end else begin
            g = m_rr; found = 1'b0;
            for (int k = 0; k < NR; k++) begin
                if (!found && rv[IW'((m_rr + k) % NR)]) begin
                    g = (m_rr + k) % NR; found = 1'b1;
                end
            end
        end
        full   = (idq.size() == MO);
        expv   = rv[IW'(g)] && !full && !c;
        exp_rr = '0;
        if (rdy && !full && !c) exp_rr[IW'(g)] = 1'b1;
        exp_rv = '0;
        if (idq.size() > 0) begin
            exp_rv[IW'(idq[0])] = dv;
            exp_drr = rrd[IW'(idq[0])];
            pop     = dv && rrd[IW'(idq[0])];
            dnext   = 1'b0;
        end else begin
            exp_drr = 1'b1; pop = 1'b0; dnext = dv;
        end
        chk("dmi_req_valid", 64'(dmi_req_valid), 64'(expv));
        chk("dmi_req", 64'(dmi_req), 64'(req[IW'(g)]));
        chk("req_ready", 64'(req_ready), 64'(exp_rr));
        chk("resp_valid", 64'(resp_valid), 64'(exp_rv));
        chk("dmi_resp_ready", 64'(dmi_resp_ready), 64'(exp_drr));
        chk("resp", 64'(resp), 64'(dmi_resp));
        chk("outstanding", 64'(outstanding), 64'(idq.size()));
        chk("resp_drop", 64'(drop), 64'(m_drop));
        s_dval = dmi_req_valid; s_addr = dmi_req.addr; s_rready = req_ready;
        s_rvalid = resp_valid; s_drr = dmi_resp_ready; s_out = int'(outstanding); s_drop = drop;
        @(posedge clk); #1;
        if (c) begin
            idq.delete(); m_rr = 0; m_lock = 1'b0;
        end else begin
            if (pop) void'(idq.pop_front());
            if (expv && rdy) begin
                idq.push_back(g); m_rr = (g + 1) % NR; m_lock = 1'b0;
            end else if (expv) begin
                m_lock = 1'b1; m_lockid = g;
            end
        end
        m_drop = dnext;
    endtask

    initial begin
        logic [1:0] op_r;
        tbl[0] = '{2'b01, 1'b1, 1'b0, 2'b11, 1'b1, 7'h10, 2'b01, 2'b00, 1'b1, 0, 1'b0};
        tbl[1] = '{2'b00, 1'b1, 1'b1, 2'b11, 1'b0, 7'h11, 2'b10, 2'b01, 1'b1, 1, 1'b0};
        tbl[2] = '{2'b11, 1'b1, 1'b0, 2'b11, 1'b1, 7'h11, 2'b10, 2'b00, 1'b1, 0, 1'b0};
        tbl[3] = '{2'b11, 1'b1, 1'b1, 2'b11, 1'b1, 7'h10, 2'b01, 2'b10, 1'b1, 1, 1'b0};
        tbl[4] = '{2'b11, 1'b1, 1'b1, 2'b11, 1'b1, 7'h11, 2'b10, 2'b01, 1'b1, 1, 1'b0};
        tbl[5] = '{2'b00, 1'b1, 1'b1, 2'b00, 1'b0, 7'h10, 2'b01, 2'b10, 1'b0, 1, 1'b0};
        tbl[6] = '{2'b00, 1'b1, 1'b1, 2'b10, 1'b0, 7'h10, 2'b01, 2'b10, 1'b1, 1, 1'b0};
        tbl[7] = '{2'b00, 1'b1, 1'b1, 2'b00, 1'b0, 7'h10, 2'b01, 2'b00, 1'b1, 0, 1'b0};
        tbl[8] = '{2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 7'h10, 2'b01, 2'b00, 1'b1, 0, 1'b1};
        tbl[9] = '{2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 7'h10, 2'b01, 2'b00, 1'b1, 0, 1'b0};

        // reset state
        do_reset();
        #1;
        chk("rst_outstanding", 64'(outstanding), 64'(0));
        chk("rst_drop", 64'(drop), 64'(0));
        chk("rst_dmi_req_valid", 64'(dmi_req_valid), 64'(0));
        chk("rst_req_ready", 64'(req_ready), 64'(0));
        chk("rst_resp_valid", 64'(resp_valid), 64'(0));
        chk("rst_dmi_resp_ready", 64'(dmi_resp_ready), 64'(1));

        // vector table: single requester, round-robin, response back-pressure, drop
        for (int i = 0; i < 10; i++) begin
            cycle(tbl[i].rv, tbl[i].rdy, 1'b0, tbl[i].dv, tbl[i].rrd);
            chk($sformatf("row%0d_dval", i), 64'(s_dval), 64'(tbl[i].e_dval));
            chk($sformatf("row%0d_addr", i), 64'(s_addr), 64'(tbl[i].e_addr));
            chk($sformatf("row%0d_req_ready", i), 64'(s_rready), 64'(tbl[i].e_rready));
            chk($sformatf("row%0d_resp_valid", i), 64'(s_rvalid), 64'(tbl[i].e_rvalid));
            chk($sformatf("row%0d_resp_ready", i), 64'(s_drr), 64'(tbl[i].e_drr));
            chk($sformatf("row%0d_out", i), 64'(s_out), 64'(tbl[i].e_out));
            chk($sformatf("row%0d_drop", i), 64'(s_drop), 64'(tbl[i].e_drop));
        end

        // lock: rr moved to 1, requester 0 stalled, requester 1 joins
        do_reset();
        cycle(2'b01, 1'b1, 1'b0, 1'b0, 2'b11);
        for (int i = 0; i < 3; i++) begin
            cycle((i == 0) ? 2'b01 : 2'b11, 1'b0, 1'b0, 1'b0, 2'b11);
            chk("lock_addr", 64'(s_addr), 64'(7'h10));
            chk("lock_valid", 64'(s_dval), 64'(1));
        end
        cycle(2'b11, 1'b1, 1'b0, 1'b0, 2'b11);
        chk("lock_release_addr", 64'(s_addr), 64'(7'h10));
        cycle(2'b11, 1'b1, 1'b0, 1'b0, 2'b11);
        chk("after_lock_addr", 64'(s_addr), 64'(7'h11));

        // full: four accepts, fifth blocked even with a same-cycle pop
        do_reset();
        for (int i = 0; i < 4; i++) cycle(2'b01, 1'b1, 1'b0, 1'b0, 2'b11);
        cycle(2'b01, 1'b1, 1'b0, 1'b1, 2'b11);
        chk("full_valid", 64'(s_dval), 64'(0));
        chk("full_ready", 64'(s_rready), 64'(0));
        chk("full_out", 64'(s_out), 64'(4));
        cycle(2'b01, 1'b1, 1'b0, 1'b0, 2'b11);
        chk("unfull_valid", 64'(s_dval), 64'(1));
        chk("unfull_ready", 64'(s_rready), 64'(1));
        chk("unfull_out", 64'(s_out), 64'(3));

        // clear: two outstanding, flush, late responses are dropped
        do_reset();
        cycle(2'b01, 1'b1, 1'b0, 1'b0, 2'b11);
        cycle(2'b01, 1'b1, 1'b0, 1'b0, 2'b11);
        cycle(2'b11, 1'b1, 1'b1, 1'b0, 2'b11);
        chk("clear_blocks", 64'(s_dval), 64'(0));
        cycle(2'b11, 1'b0, 1'b0, 1'b1, 2'b11);
        chk("clear_out", 64'(s_out), 64'(0));
        chk("clear_rr", 64'(s_addr), 64'(7'h10));
        chk("clear_no_resp", 64'(s_rvalid), 64'(0));
        cycle(2'b00, 1'b0, 1'b0, 1'b1, 2'b11);
        chk("clear_drop1", 64'(s_drop), 64'(1));
        cycle(2'b00, 1'b0, 1'b0, 1'b0, 2'b11);
        chk("clear_drop2", 64'(s_drop), 64'(1));
        cycle(2'b00, 1'b0, 1'b0, 1'b0, 2'b11);
        chk("clear_drop_end", 64'(s_drop), 64'(0));

        // randomized traffic against the model
        do_reset();
        for (int n = 0; n < 500; n++) begin
            for (int i = 0; i < NR; i++) begin
                op_r = 2'($urandom_range(0, 2));
                req[IW'(i)].addr = 7'($urandom);
                req[IW'(i)].op   = dm::dtm_op_e'(op_r);
                req[IW'(i)].data = $urandom;
            end
            dmi_resp.data = $urandom;
            dmi_resp.resp = 2'($urandom);
            cycle(NR'($urandom), ($urandom_range(0, 9) < 7), ($urandom_range(0, 39) == 0),
                  1'($urandom), NR'($urandom));
        end

        // asynchronous reset while locked with three outstanding
        do_reset();
        for (int i = 0; i < 3; i++) cycle(2'b01, 1'b1, 1'b0, 1'b0, 2'b11);
        cycle(2'b01, 1'b0, 1'b0, 1'b0, 2'b11);
        req_valid = 2'b11; dmi_req_ready = 1'b0; dmi_resp_valid = 1'b1; resp_ready = 2'b11;
        #1;
        chk("pre_rst_out", 64'(outstanding), 64'(3));
        chk("pre_rst_valid", 64'(dmi_req_valid), 64'(1));
        rst_n = 1'b0;
        #1;
        chk("async_rst_out", 64'(outstanding), 64'(0));
        chk("async_rst_valid", 64'(dmi_req_valid), 64'(0));
        chk("async_rst_req_ready", 64'(req_ready), 64'(0));
        chk("async_rst_resp_valid", 64'(resp_valid), 64'(0));
        chk("async_rst_resp_ready", 64'(dmi_resp_ready), 64'(1));
        chk("async_rst_drop", 64'(drop), 64'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        cycle(2'b10, 1'b1, 1'b0, 1'b0, 2'b11);
        chk("post_rst_addr", 64'(s_addr), 64'(7'h11));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
